// File: rtl/fft_frame_streamer.sv
// Transmit end of the FFT bin stream: collects complex samples into a
// ping-pong buffer and replays each completed frame as one contiguous burst
// (index 0..N-1). Every burst is followed by a mandatory idle gap.
module fft_frame_streamer #(
  parameter int N_LOG2 = 10,
  parameter int DW     = 28,
  parameter int GAP    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_re,
  input  logic [DW-1:0]     in_im,
  output logic              opd_o,
  output logic [N_LOG2-1:0] idx_o,
  output logic [DW-1:0]     fft_real,
  output logic [DW-1:0]     fft_imag,
  output logic              frame_done,
  output logic              overflow,
  output logic [15:0]       frame_cnt
);
  localparam int N  = 1 << N_LOG2;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_GAP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [2*DW-1:0]   r_mem0 [N];
  logic [2*DW-1:0]   r_mem1 [N];
  logic [2*DW-1:0]   r_rd_q;

  logic [N_LOG2-1:0] r_wr_ptr;
  logic [N_LOG2-1:0] r_rd_addr;
  logic              r_wr_bank;
  logic              r_bank_busy;
  logic              r_pending;
  logic [GW-1:0]     r_gap_cnt;

  logic              r_opd;
  logic [N_LOG2-1:0] r_idx;
  logic [DW-1:0]     r_real;
  logic [DW-1:0]     r_imag;
  logic              r_frame_done;
  logic              r_overflow;
  logic [15:0]       r_frame_cnt;

  logic [N_LOG2-1:0] w_beat;
  logic              w_last_beat;
  logic              w_fill;
  logic              w_swap;
  logic              w_release;
  logic              w_take;
  logic              w_rd_en;

  // The beat being presented is one behind the address already issued to RAM.
  assign w_beat      = r_rd_addr - N_LOG2'(1);
  assign w_last_beat = (w_beat == '1);
  assign w_fill      = in_valid && (r_wr_ptr == '1);
  // A release in the fill cycle frees the read bank just in time to swap.
  assign w_swap      = w_fill && (!r_bank_busy || w_release);
  assign w_rd_en     = (r_state == S_PRIME) || (r_state == S_STREAM);

  // Next-state logic plus the pending-take and bank-release strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_release   = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_take      = 1'b1;
          w_state_nxt = S_PRIME;
        end
      end
      S_PRIME:  w_state_nxt = S_STREAM;
      S_STREAM: if (w_last_beat) w_state_nxt = S_GAP;
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Write side: pointer, bank selection, busy/pending flags, overflow pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_wr_bank   <= 1'b0;
      r_bank_busy <= 1'b0;
      r_pending   <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_overflow <= w_fill && !w_swap;
      if (in_valid) r_wr_ptr <= r_wr_ptr + N_LOG2'(1);
      if (w_swap) begin
        r_wr_bank   <= ~r_wr_bank;
        r_bank_busy <= 1'b1;
        r_pending   <= 1'b1;
      end else begin
        if (w_release) r_bank_busy <= 1'b0;
        if (w_take)    r_pending   <= 1'b0;
      end
    end
  end

  // Sample storage: real part in the upper half of each word.
  always_ff @(posedge clk) begin
    if (in_valid && !r_wr_bank) r_mem0[r_wr_ptr] <= {in_re, in_im};
    if (in_valid &&  r_wr_bank) r_mem1[r_wr_ptr] <= {in_re, in_im};
  end

  // Synchronous read from the bank not being written.
  always_ff @(posedge clk) begin
    if (w_rd_en) r_rd_q <= r_wr_bank ? r_mem0[r_rd_addr] : r_mem1[r_rd_addr];
  end

  // Read address, gap timing and registered burst outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_addr    <= '0;
      r_gap_cnt    <= '0;
      r_opd        <= 1'b0;
      r_idx        <= '0;
      r_real       <= '0;
      r_imag       <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_opd        <= (r_state == S_STREAM);
      r_idx        <= (r_state == S_STREAM) ? w_beat : '0;
      r_real       <= (r_state == S_STREAM) ? r_rd_q[2*DW-1:DW] : '0;
      r_imag       <= (r_state == S_STREAM) ? r_rd_q[DW-1:0]    : '0;
      r_frame_done <= (r_state == S_GAP) && (r_gap_cnt == '0);
      if ((r_state == S_GAP) && (r_gap_cnt == '0))
        r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_take)        r_rd_addr <= '0;
      else if (w_rd_en)  r_rd_addr <= r_rd_addr + N_LOG2'(1);
      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + GW'(1);
      else                  r_gap_cnt <= '0;
    end
  end

  assign opd_o      = r_opd;
  assign idx_o      = r_idx;
  assign fft_real   = r_real;
  assign fft_imag   = r_imag;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign frame_cnt  = r_frame_cnt;

endmodule
